// File: rtl/datapath_param.sv
// datapath_param: parametrised register-file / shifter / ALU datapath.
// The register file, A, B, C and the {V,N,Z} status register are all cleared
// asynchronously by reset_n. Every storage element updates only on its own strobe.
// Register indices at or above NREGS are treated as absent:
//   - a write to such an index is dropped;
//   - a read from such an index returns zero.
module datapath_param #(
   parameter int W     = 16,
   parameter int NREGS = 8,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          write,
   input  logic [RW-1:0] writenum,
   input  logic [RW-1:0] readnum,
   input  logic [1:0]    vsel,
   input  logic [W-1:0]  sximm8,
   input  logic [W-1:0]  sximm5,
   input  logic [W-1:0]  mdata,
   input  logic [W-1:0]  pc_in,
   input  logic          loada,
   input  logic          loadb,
   input  logic          asel,
   input  logic          bsel,
   input  logic [1:0]    shift,
   input  logic [1:0]    ALUop,
   input  logic          loadc,
   input  logic          loads,
   output logic [2:0]    Z_out,
   output logic [W-1:0]  datapath_out
);

   logic [W-1:0] regs_r [NREGS];
   logic [W-1:0] a_r;
   logic [W-1:0] b_r;
   logic [W-1:0] c_r;
   logic [2:0]   status_r;

   logic [W-1:0] wb_data_s;
   logic [W-1:0] rd_data_s;
   logic [W-1:0] shifted_s;
   logic [W-1:0] ain_s;
   logic [W-1:0] bin_s;
   logic [W-1:0] alu_s;
   logic         ovf_s;
   logic [2:0]   flags_s;

   // Writeback source select; C is the registered value, never the live ALU result
   always_comb begin
      wb_data_s = {W{1'b0}};
      case (vsel)
         2'b00:   wb_data_s = c_r;
         2'b01:   wb_data_s = pc_in;
         2'b10:   wb_data_s = sximm8;
         2'b11:   wb_data_s = mdata;
         default: wb_data_s = {W{1'b0}};
      endcase
   end

   // Register file storage: indexed write, out-of-range indices match no entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (write && (writenum == RW'(i))) begin
               regs_r[i] <= wb_data_s;
            end
         end
      end
   end

   // Combinational read port; an unmatched (out-of-range) index yields zero
   always_comb begin
      rd_data_s = {W{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
         rd_data_s = rd_data_s | (regs_r[i] & {W{readnum == RW'(i)}});
      end
   end

   // A and B operand registers capture the pre-write read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_r <= {W{1'b0}};
         b_r <= {W{1'b0}};
      end else begin
         if (loada) begin
            a_r <= rd_data_s;
         end
         if (loadb) begin
            b_r <= rd_data_s;
         end
      end
   end

   // Single-bit shifter on the B path
   always_comb begin
      shifted_s = b_r;
      case (shift)
         2'b00:   shifted_s = b_r;
         2'b01:   shifted_s = {b_r[W-2:0], 1'b0};
         2'b10:   shifted_s = {1'b0, b_r[W-1:1]};
         2'b11:   shifted_s = {b_r[W-1], b_r[W-1:1]};
         default: shifted_s = b_r;
      endcase
   end

   // Operand muxes, four-op ALU and signed-overflow detection
   always_comb begin
      if (asel) begin
         ain_s = {W{1'b0}};
      end else begin
         ain_s = a_r;
      end
      if (bsel) begin
         bin_s = sximm5;
      end else begin
         bin_s = shifted_s;
      end
      alu_s = {W{1'b0}};
      ovf_s = 1'b0;
      case (ALUop)
         2'b00: begin
            alu_s = ain_s + bin_s;
            ovf_s = (ain_s[W-1] == bin_s[W-1]) && (alu_s[W-1] != ain_s[W-1]);
         end
         2'b01: begin
            alu_s = ain_s - bin_s;
            ovf_s = (ain_s[W-1] != bin_s[W-1]) && (alu_s[W-1] != ain_s[W-1]);
         end
         2'b10: begin
            alu_s = ain_s & bin_s;
            ovf_s = 1'b0;
         end
         2'b11: begin
            alu_s = ~bin_s;
            ovf_s = 1'b0;
         end
         default: begin
            alu_s = {W{1'b0}};
            ovf_s = 1'b0;
         end
      endcase
      flags_s = {ovf_s, alu_s[W-1], (alu_s == {W{1'b0}})};
   end

   // C result and status registers, loaded independently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_r      <= {W{1'b0}};
         status_r <= 3'b000;
      end else begin
         if (loadc) begin
            c_r <= alu_s;
         end
         if (loads) begin
            status_r <= flags_s;
         end
      end
   end

   assign datapath_out = c_r;
   assign Z_out        = status_r;

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param.
// It drives three instances from shared strobes:
//   - inst 0: W=16, NREGS=8
//   - inst 1: W=16, NREGS=6
//   - inst 2: W=32, NREGS=8
// Stimulus pushes hand-computed expectations into a queue.
// A separate monitor pops each expectation and compares it at the falling edge,
// or immediately when an asynchronous check is signalled.
module tb_datapath_param;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        write, loada, loadb, asel, bsel, loadc, loads;
   logic [2:0]  writenum, readnum;
   logic [1:0]  vsel, shift, alu_op;
   logic [31:0] sx8, sx5, mdata, pc;
   logic [2:0]  z0, z6, z32;
   logic [15:0] o0, o6;
   logic [31:0] o32;

   typedef struct {
      int          inst;
      string       name;
      logic [31:0] out;
      logic [2:0]  z;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   event smp_ev;

   always #5 clk = ~clk;

   datapath_param #(.W(16), .NREGS(8)) d0 (
      .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .readnum(readnum),
      .vsel(vsel), .sximm8(sx8[15:0]), .sximm5(sx5[15:0]), .mdata(mdata[15:0]), .pc_in(pc[15:0]),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
      .loadc(loadc), .loads(loads), .Z_out(z0), .datapath_out(o0)
   );

   datapath_param #(.W(16), .NREGS(6)) d6 (
      .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .readnum(readnum),
      .vsel(vsel), .sximm8(sx8[15:0]), .sximm5(sx5[15:0]), .mdata(mdata[15:0]), .pc_in(pc[15:0]),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
      .loadc(loadc), .loads(loads), .Z_out(z6), .datapath_out(o6)
   );

   datapath_param #(.W(32), .NREGS(8)) d32 (
      .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .readnum(readnum),
      .vsel(vsel), .sximm8(sx8), .sximm5(sx5), .mdata(mdata), .pc_in(pc),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
      .loadc(loadc), .loads(loads), .Z_out(z32), .datapath_out(o32)
   );

   // Monitor: pop and compare every pending expectation
   initial begin
      exp_t        e;
      logic [31:0] got_o;
      logic [2:0]  got_z;
      forever begin
         @(negedge clk or smp_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.inst)
               0:       begin got_o = {16'h0000, o0}; got_z = z0;  end
               1:       begin got_o = {16'h0000, o6}; got_z = z6;  end
               default: begin got_o = o32;            got_z = z32; end
            endcase
            tests++;
            if ((got_o !== e.out) || (got_z !== e.z)) begin
               fails++;
               $display("FAIL %s (inst %0d): datapath_out=%h Z_out=%b, expected %h %b",
                        e.name, e.inst, got_o, got_z, e.out, e.z);
            end
         end
      end
   end

   task automatic clr();
      write = 1'b0; loada = 1'b0; loadb = 1'b0; asel = 1'b0; bsel = 1'b0;
      loadc = 1'b0; loads = 1'b0; writenum = 3'd0; readnum = 3'd0;
      vsel = 2'b00; shift = 2'b00; alu_op = 2'b00;
      sx8 = 32'd0; sx5 = 32'd0; mdata = 32'd0; pc = 32'd0;
   endtask

   task automatic push(input int inst, input string nm, input logic [31:0] o, input logic [2:0] z);
      exp_t e;
      e.inst = inst; e.name = nm; e.out = o; e.z = z;
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
   endtask

   task automatic nxt();
      @(negedge clk);
      clr();
   endtask

   task automatic wr(input logic [2:0] n, input logic [31:0] v);
      write = 1'b1; writenum = n; vsel = 2'b10; sx8 = v;
      cyc(); nxt();
   endtask

   task automatic rd_a(input logic [2:0] n);
      readnum = n; loada = 1'b1;
      cyc(); nxt();
   endtask

   task automatic rd_b(input logic [2:0] n);
      readnum = n; loadb = 1'b1;
      cyc(); nxt();
   endtask

   task automatic op(input logic [1:0] aop, input logic [1:0] sh, input logic as, input logic bs,
                     input logic [31:0] imm5, input logic lc, input logic ls);
      alu_op = aop; shift = sh; asel = as; bsel = bs; sx5 = imm5; loadc = lc; loads = ls;
      cyc();
   endtask

   // Directed stimulus
   initial begin
      clr();
      reset_n = 1'b0;
      #12;
      push(0, "reset_state", 32'h0, 3'b000);
      push(1, "reset_state", 32'h0, 3'b000);
      push(2, "reset_state", 32'h0, 3'b000);
      ->smp_ev;
      @(negedge clk);
      reset_n = 1'b1;

      // Test 1: 13 + 42, then write C back to R2 and read it out
      wr(3'd3, 32'd42); wr(3'd5, 32'd13); rd_b(3'd3); rd_a(3'd5);
      op(2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t1_add", 32'd55, 3'b000); push(1, "t1_add", 32'd55, 3'b000);
      push(2, "t1_add", 32'd55, 3'b000);
      nxt();
      write = 1'b1; writenum = 3'd2; vsel = 2'b00; cyc(); nxt();
      rd_a(3'd2);
      op(2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
      push(0, "t1_wb_c", 32'd55, 3'b000); push(1, "t1_wb_c", 32'd55, 3'b000);
      push(2, "t1_wb_c", 32'd55, 3'b000);
      nxt();

      // Test 2: shifter modes
      rd_b(3'd3);
      op(2'b00, 2'b10, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t2_lsr", 32'd21, 3'b000); push(2, "t2_lsr", 32'd21, 3'b000);
      nxt();
      wr(3'd4, 32'h0000_8000); rd_b(3'd4);
      op(2'b00, 2'b11, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t2_asr", 32'h0000_C000, 3'b010); push(2, "t2_asr", 32'h0000_4000, 3'b000);
      nxt();
      op(2'b00, 2'b01, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t2_lsl_zero", 32'h0, 3'b001); push(2, "t2_lsl", 32'h0001_0000, 3'b000);
      nxt();

      // Test 3: negative SUB result and signed overflow on ADD
      rd_a(3'd5); rd_b(3'd3);
      op(2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t3_sub", 32'h0000_FFE3, 3'b010); push(2, "t3_sub", 32'hFFFF_FFE3, 3'b010);
      nxt();
      wr(3'd7, 32'h7FFF_FFFF); wr(3'd6, 32'h0000_7FFF); rd_a(3'd6);
      op(2'b00, 2'b00, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1);
      push(0, "t3_ovf", 32'h0000_8000, 3'b110); push(2, "t3_no_ovf32", 32'h0000_8000, 3'b000);
      push(1, "t5_rd6_zero", 32'd1, 3'b000);
      nxt();
      rd_a(3'd7);
      op(2'b00, 2'b00, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1);
      push(2, "t5_ovf32", 32'h8000_0000, 3'b110); push(0, "t3_wrap", 32'h0, 3'b001);
      push(1, "t5_rd7_zero", 32'd1, 3'b000);
      nxt();

      // AND / NOT, then loadc and loads used independently
      rd_a(3'd5);
      op(2'b10, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "and", 32'd8, 3'b000); nxt();
      op(2'b11, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "not", 32'h0000_FFD5, 3'b010); nxt();
      op(2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      push(0, "loadc_only", 32'd55, 3'b010); nxt();
      op(2'b10, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      push(0, "loads_only", 32'd55, 3'b000); nxt();

      // Test 4: same-edge write and read of R1 sees the old value
      write = 1'b1; writenum = 3'd1; vsel = 2'b10; sx8 = 32'd7; readnum = 3'd1; loadb = 1'b1;
      cyc(); nxt();
      op(2'b00, 2'b00, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t4_no_bypass", 32'd0, 3'b001); nxt();
      rd_b(3'd1);
      op(2'b00, 2'b00, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "t4_next_cycle", 32'd7, 3'b000); nxt();

      // C update plus writeback of C on the same edge stores the old C
      write = 1'b1; writenum = 3'd0; vsel = 2'b00;
      op(2'b00, 2'b00, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1);
      push(0, "c_update", 32'd3, 3'b000); nxt();
      rd_a(3'd0);
      op(2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
      push(0, "wb_old_c", 32'd7, 3'b000); nxt();

      // pc_in and mdata writeback paths
      write = 1'b1; writenum = 3'd0; vsel = 2'b01; pc = 32'h0000_1234; cyc(); nxt();
      write = 1'b1; writenum = 3'd1; vsel = 2'b11; mdata = 32'h0000_00A5; cyc(); nxt();
      rd_a(3'd0); rd_b(3'd1);
      op(2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      push(0, "pc_minus_mdata", 32'h0000_118F, 3'b000); nxt();

      // Test 6: asynchronous reset between edges with strobes active
      loadc = 1'b1; loads = 1'b1; write = 1'b1; writenum = 3'd2; vsel = 2'b10; sx8 = 32'd5;
      loada = 1'b1; loadb = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      push(0, "t6_async_rst", 32'h0, 3'b000); push(1, "t6_async_rst", 32'h0, 3'b000);
      push(2, "t6_async_rst", 32'h0, 3'b000);
      ->smp_ev;
      cyc();
      push(0, "t6_rst_held", 32'h0, 3'b000); push(2, "t6_rst_held", 32'h0, 3'b000);
      @(negedge clk);
      clr();
      reset_n = 1'b1;
      for (int r = 0; r < 8; r++) begin
         rd_a(3'(r));
         op(2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
         push(0, $sformatf("t6_reg%0d_zero", r), 32'h0, 3'b001);
         push(2, $sformatf("t6_reg%0d_zero", r), 32'h0, 3'b001);
         nxt();
      end

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge clk);
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
